// File: rtl/acorn_pkg.sv
// Shared ACORN-128 definitions: widths, step counts, FSM encoding and the
// bit-level feedback, keystream and nonlinear feedback functions.
package acorn_pkg;

    localparam int STATE_W   = 293;
    localparam int TAG_W     = 128;
    localparam int FIN_STEPS = 768;
    localparam int PAD_STEPS = 256;
    localparam int CNT_W     = 10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CT,
        DEC,
        OUT,
        PAD,
        FIN,
        CMP
    } fsm_e;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // Six LFSR feedbacks; each one reads only pre-update bits.
    function automatic logic [STATE_W-1:0] acorn_lfsr_fb(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] t;
        t      = s;
        t[289] = s[289] ^ s[235] ^ s[230];
        t[230] = s[230] ^ s[196] ^ s[193];
        t[193] = s[193] ^ s[160] ^ s[154];
        t[154] = s[154] ^ s[111] ^ s[107];
        t[107] = s[107] ^ s[66]  ^ s[61];
        t[61]  = s[61]  ^ s[23]  ^ s[0];
        return t;
    endfunction

    function automatic logic acorn_ks(input logic [STATE_W-1:0] s);
        return s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
    endfunction

    function automatic logic acorn_f(input logic [STATE_W-1:0] s, input logic ca,
                                     input logic cb, input logic ks);
        return s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);
    endfunction

endpackage

// File: rtl/acorn_step.sv
// One combinational ACORN-128 state update; decrypt_en selects whether the
// recovered plaintext bit or c_bit itself is folded back into the state.
module acorn_step
    import acorn_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic               ca,
    input  logic               cb,
    input  logic               c_bit,
    input  logic               decrypt_en,
    output logic [STATE_W-1:0] next_state,
    output logic               ks,
    output logic               p_bit
);

    logic [STATE_W-1:0] fb;
    logic               f;
    logic               m;

    always_comb begin
        fb         = acorn_lfsr_fb(state);
        ks         = acorn_ks(fb);
        p_bit      = c_bit ^ ks;
        m          = decrypt_en ? p_bit : c_bit;
        f          = acorn_f(fb, ca, cb, ks);
        next_state = {f ^ m, fb[STATE_W-1:1]};
    end

endmodule

// File: rtl/acorn128_decrypt.sv
// ACORN-128 receive engine: bit-serial ciphertext decryption followed by
// padding, finalization and a registered tag comparison.
module acorn128_decrypt
    import acorn_pkg::*;
#(
    parameter int FIN_STEPS_P = FIN_STEPS,
    parameter int PAD_STEPS_P = PAD_STEPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               msg_empty,
    input  logic [STATE_W-1:0] state_in,
    input  logic [TAG_W-1:0]   tag_in,
    input  logic               ct_valid,
    output logic               ct_ready,
    input  logic [7:0]         ct_data,
    input  logic               ct_last,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [7:0]         pt_data,
    output logic               busy,
    output logic               done,
    output logic               tag_ok
);

    localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(PAD_STEPS_P - 1);
    localparam logic [CNT_W-1:0] PAD_HALF = CNT_W'(PAD_STEPS_P / 2);
    localparam logic [CNT_W-1:0] FIN_LAST = CNT_W'(FIN_STEPS_P - 1);
    localparam logic [CNT_W-1:0] FIN_TAG0 = CNT_W'(FIN_STEPS_P - TAG_W);

    fsm_e               fsm;
    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   step_cnt;
    logic [7:0]         ct_sr;
    logic [7:0]         pt_sr;
    logic [TAG_W-1:0]   tag_sr;
    logic [TAG_W-1:0]   tag_ref;
    logic               last_byte;

    logic               ca;
    logic               cb;
    logic               c_bit;
    logic               dec_en;
    logic [STATE_W-1:0] next_state;
    logic               ks;
    logic               p_bit;

    assign pt_data = pt_sr;

    // Padding injects a single 1 on its first step and drops ca halfway through.
    always_comb begin
        ca     = 1'b1;
        cb     = 1'b0;
        c_bit  = 1'b0;
        dec_en = 1'b0;
        unique case (fsm)
            DEC: begin
                c_bit  = ct_sr[0];
                dec_en = 1'b1;
            end
            PAD: begin
                c_bit = (step_cnt == '0);
                ca    = (step_cnt < PAD_HALF);
            end
            FIN: cb = 1'b1;
            default: ;
        endcase
    end

    acorn_step u_step (
        .state      (state),
        .ca         (ca),
        .cb         (cb),
        .c_bit      (c_bit),
        .decrypt_en (dec_en),
        .next_state (next_state),
        .ks         (ks),
        .p_bit      (p_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            state     <= '0;
            step_cnt  <= '0;
            ct_sr     <= '0;
            pt_sr     <= '0;
            tag_sr    <= '0;
            tag_ref   <= '0;
            last_byte <= 1'b0;
            ct_ready  <= 1'b0;
            pt_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tag_ok    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (start) begin
                        state    <= state_in;
                        tag_ref  <= tag_in;
                        tag_sr   <= '0;
                        tag_ok   <= 1'b0;
                        busy     <= 1'b1;
                        step_cnt <= '0;
                        if (msg_empty) begin
                            fsm <= PAD;
                        end else begin
                            fsm      <= WAIT_CT;
                            ct_ready <= 1'b1;
                        end
                    end
                end
                WAIT_CT: begin
                    if (ct_valid && ct_ready) begin
                        ct_sr     <= ct_data;
                        last_byte <= ct_last;
                        ct_ready  <= 1'b0;
                        step_cnt  <= '0;
                        fsm       <= DEC;
                    end
                end
                DEC: begin
                    state <= next_state;
                    ct_sr <= ct_sr >> 1;
                    pt_sr <= {p_bit, pt_sr[7:1]};
                    if (step_cnt == CNT_W'(7)) begin
                        step_cnt <= '0;
                        pt_valid <= 1'b1;
                        fsm      <= OUT;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (pt_ready) begin
                        pt_valid <= 1'b0;
                        step_cnt <= '0;
                        if (last_byte) begin
                            fsm <= PAD;
                        end else begin
                            fsm      <= WAIT_CT;
                            ct_ready <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    state <= next_state;
                    if (step_cnt == PAD_LAST) begin
                        step_cnt <= '0;
                        fsm      <= FIN;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                FIN: begin
                    state <= next_state;
                    // The last 128 keystream bits form the tag, first bit ending at bit 0.
                    if (step_cnt >= FIN_TAG0) begin
                        tag_sr <= {ks, tag_sr[TAG_W-1:1]};
                    end
                    if (step_cnt == FIN_LAST) begin
                        step_cnt <= '0;
                        fsm      <= CMP;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                CMP: begin
                    tag_ok <= (tag_sr == tag_ref);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    fsm    <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acorn128_decrypt.sv
// Bench for acorn128_decrypt: an encrypt-side ACORN model builds ciphertext and
// tags; decrypted bytes are scoreboarded and done timing is counted in cycles.
module tb_acorn128_decrypt;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         msg_empty = 1'b0;
    logic [292:0] state_in = '0;
    logic [127:0] tag_in = '0;
    logic         ct_valid = 1'b0;
    logic         ct_ready;
    logic [7:0]   ct_data = '0;
    logic         ct_last = 1'b0;
    logic         pt_valid;
    logic         pt_ready = 1'b0;
    logic [7:0]   pt_data;
    logic         busy;
    logic         done;
    logic         tag_ok;

    int total = 0;
    int bad   = 0;

    bit [292:0] s_ad;
    bit [7:0]   pt_bytes[16];
    bit [7:0]   ct_bytes[16];
    bit [127:0] tag_good;
    bit [127:0] tag_empty;
    bit [7:0]   exp_q[$];

    always #5 clk = ~clk;

    acorn128_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .msg_empty (msg_empty),
        .state_in  (state_in),
        .tag_in    (tag_in),
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .ct_data   (ct_data),
        .ct_last   (ct_last),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .pt_data   (pt_data),
        .busy      (busy),
        .done      (done),
        .tag_ok    (tag_ok)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit maj3(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    // Encrypt-direction step: msg is absorbed directly, out = msg ^ ks.
    task automatic model_step(inout bit [292:0] s, input bit ca, input bit cb,
                              input bit msg, output bit ks, output bit out);
        bit [292:0] u;
        bit         f;
        u      = s;
        u[289] = s[289] ^ s[235] ^ s[230];
        u[230] = s[230] ^ s[196] ^ s[193];
        u[193] = s[193] ^ s[160] ^ s[154];
        u[154] = s[154] ^ s[111] ^ s[107];
        u[107] = s[107] ^ s[66]  ^ s[61];
        u[61]  = s[61]  ^ s[23]  ^ s[0];
        ks  = u[12] ^ u[154] ^ maj3(u[235], u[61], u[193]) ^ (u[230] ? u[111] : u[66]);
        f   = u[0] ^ !u[107] ^ maj3(u[244], u[23], u[160]) ^ (ca & u[196]) ^ (cb & ks);
        out = msg ^ ks;
        s   = {f ^ msg, u[292:1]};
    endtask

    task automatic model_tail(inout bit [292:0] s, output bit [127:0] tag);
        bit ks;
        bit o;
        for (int i = 0; i < 256; i++) model_step(s, bit'(i < 128), 1'b0, bit'(i == 0), ks, o);
        for (int i = 0; i < 768; i++) begin
            model_step(s, 1'b1, 1'b1, 1'b0, ks, o);
            if (i >= 640) tag[i-640] = ks;
        end
    endtask

    // key=0, iv=0, empty AD, then 16 plaintext bytes 0x00..0x0F.
    task automatic model_build;
        bit [292:0] s;
        bit         ks;
        bit         o;
        s = '0;
        for (int i = 0; i < 1792; i++) model_step(s, 1'b1, 1'b1, bit'(i == 256), ks, o);
        for (int i = 0; i < 256; i++) model_step(s, bit'(i < 128), 1'b1, bit'(i == 0), ks, o);
        s_ad = s;
        model_tail(s, tag_empty);
        s = s_ad;
        for (int b = 0; b < 16; b++) begin
            pt_bytes[b] = 8'(b);
            for (int j = 0; j < 8; j++) begin
                model_step(s, 1'b1, 1'b0, pt_bytes[b][j], ks, o);
                ct_bytes[b][j] = o;
            end
        end
        model_tail(s, tag_good);
    endtask

    task automatic do_start(input bit empty, input bit [127:0] tag);
        start     = 1'b1;
        msg_empty = empty;
        state_in  = s_ad;
        tag_in    = tag;
        tick;
        start     = 1'b0;
        msg_empty = 1'b0;
    endtask

    task automatic feed_byte(input int idx, input bit last, input int hold);
        int         waitc;
        int         lat;
        bit [7:0]   first;
        bit [7:0]   exp;
        bit         stall_err;
        waitc = 0;
        while (ct_ready !== 1'b1 && waitc < 50) begin
            tick;
            waitc++;
        end
        total++;
        if (ct_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ct_ready_wait byte %0d: got %b want 1", idx, ct_ready);
            return;
        end
        ct_valid = 1'b1;
        ct_data  = ct_bytes[idx];
        ct_last  = last;
        exp_q.push_back(pt_bytes[idx]);
        tick;
        ct_valid = 1'b0;
        ct_last  = 1'b0;
        ct_data  = 8'hFF;
        lat = 0;
        while (pt_valid !== 1'b1 && lat < 50) begin
            tick;
            lat++;
        end
        total++;
        if (lat !== 8) begin
            bad++;
            $display("[TB] FAIL latency byte %0d: got %0d want 8 cycles after accept", idx, lat);
        end
        if (hold > 0) begin
            first     = pt_data;
            stall_err = 1'b0;
            for (int h = 0; h < hold; h++) begin
                tick;
                if (ct_ready !== 1'b0 || pt_valid !== 1'b1 || pt_data !== first) stall_err = 1'b1;
            end
            total++;
            if (stall_err) begin
                bad++;
                $display("[TB] FAIL backpressure byte %0d: got ready=%b valid=%b data=%h want 0 1 %h",
                         idx, ct_ready, pt_valid, pt_data, first);
            end
        end
        pt_ready = 1'b1;
        exp = exp_q.pop_front();
        total++;
        if (pt_data !== exp) begin
            bad++;
            $display("[TB] FAIL pt_data byte %0d: got %h want %h", idx, pt_data, exp);
        end
        tick;
        pt_ready = 1'b0;
    endtask

    // Counts cycles from the current edge until done; also watches for a stray ct_ready.
    task automatic wait_done(input string name, input bit noisy, input bit exp_ok);
        int cnt;
        bit ready_seen;
        bit busy_drop;
        cnt        = 0;
        ready_seen = 1'b0;
        busy_drop  = 1'b0;
        while (done !== 1'b1 && cnt < 2000) begin
            tick;
            cnt++;
            if (ct_ready === 1'b1) ready_seen = 1'b1;
            if (done !== 1'b1 && busy !== 1'b1) busy_drop = 1'b1;
            if (noisy) begin
                if (cnt == 5)   begin ct_valid = 1'b1; ct_data = 8'hA5; end
                if (cnt == 300) start = 1'b1;
                if (cnt == 301) start = 1'b0;
            end
        end
        ct_valid = 1'b0;
        total++;
        if (cnt !== 1025) begin
            bad++;
            $display("[TB] FAIL %s done_timing: got %0d want 1025 cycles", name, cnt);
        end
        total++;
        if (ready_seen || busy_drop) begin
            bad++;
            $display("[TB] FAIL %s tail_flags: got ready_seen=%b busy_drop=%b want 0 0",
                     name, ready_seen, busy_drop);
        end
        total++;
        if (tag_ok !== exp_ok || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s tag_ok: got tag_ok=%b busy=%b want %b 0", name, tag_ok, busy, exp_ok);
        end
        tick;
        total++;
        if (done !== 1'b0 || tag_ok !== exp_ok) begin
            bad++;
            $display("[TB] FAIL %s done_pulse: got done=%b tag_ok=%b want 0 %b", name, done, tag_ok, exp_ok);
        end
    endtask

    task automatic run_message(input string name, input bit [127:0] tag, input int stall_byte,
                               input bit noisy, input bit exp_ok);
        do_start(1'b0, tag);
        for (int i = 0; i < 16; i++) feed_byte(i, i == 15, (i == stall_byte) ? 20 : 0);
        wait_done(name, noisy, exp_ok);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL %s scoreboard_left: got %0d want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total++;
        if ({busy, done, tag_ok, pt_valid, ct_ready, pt_data} !== 13'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b%b%b%b%b %h want all 0",
                     busy, done, tag_ok, pt_valid, ct_ready, pt_data);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_round_trip;
        run_message("round_trip", tag_good, -1, 1'b0, 1'b1);
    endtask

    task automatic test_tag_tamper;
        run_message("tamper", tag_good ^ 128'd1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_empty;
        do_start(1'b1, tag_empty);
        wait_done("empty", 1'b0, 1'b1);
    endtask

    task automatic test_backpressure;
        run_message("backpressure", tag_good, 3, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        bit done_seen;
        do_start(1'b0, tag_good);
        ct_valid = 1'b1;
        ct_data  = ct_bytes[0];
        tick;
        ct_valid = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, pt_valid, ct_ready, tag_ok, done} !== 5'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid: got busy=%b pv=%b cr=%b ok=%b done=%b want all 0",
                     busy, pt_valid, ct_ready, tag_ok, done);
        end
        tick;
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
        end
        total++;
        if (done_seen) begin
            bad++;
            $display("[TB] FAIL reset_mid_idle: got done/busy activity want none");
        end
        run_message("after_reset", tag_good, -1, 1'b0, 1'b1);
    endtask

    task automatic test_ignored;
        run_message("ignored", tag_good, -1, 1'b1, 1'b1);
    endtask

    initial begin
        model_build;
        test_reset;
        test_round_trip;
        test_tag_tamper;
        test_empty;
        test_backpressure;
        test_reset_mid;
        test_ignored;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
